// File: rtl/battle_transition.sv
// battle_transition: frame-synchronised overworld-to-battle screen sequencer.
// Flashes the screen, closes black bars from top and bottom, hands off to the
// battle engine, then reopens the bars once the battle reports completion.
//
// Ports:
//   vclk           pixel clock (sole clock)
//   reset          asynchronous, active-high
//   hcount/vcount  current pixel position from the video timing generator
//   battle_trigger one-cycle request from the player controller
//   battle_done    one-cycle completion pulse from the battle engine
//   pixel_in       overworld RGB444 for (hcount, vcount)
//   pixel_out      processed RGB444, one cycle of latency
//   game_mode      0 = overworld, 1 = transition, 2 = battle
//   freeze         high whenever the sequencer is not idle
//   battle_start   one-cycle pulse on entry to battle
module battle_transition #(
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int FLASH_FRAMES = 4,
    parameter int FLASH_COUNT  = 3,
    parameter int WIPE_STEP    = 8
) (
    input  logic        vclk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        battle_trigger,
    input  logic        battle_done,
    input  logic [11:0] pixel_in,
    output logic [11:0] pixel_out,
    output logic [1:0]  game_mode,
    output logic        freeze,
    output logic        battle_start
);

    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int PW = $clog2(2 * FLASH_COUNT);

    localparam logic [FW-1:0] FCNT_LAST  = FW'(FLASH_FRAMES - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * FLASH_COUNT - 1);
    localparam logic [9:0]    HALF       = 10'(V_ACTIVE / 2);
    localparam logic [9:0]    STEP       = 10'(WIPE_STEP);
    localparam logic [9:0]    VMAX       = 10'(V_ACTIVE);
    localparam logic [10:0]   HMAX       = 11'(H_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLASH,
        S_WIPE,
        S_BATTLE,
        S_OPEN
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [9:0]      bar;
    logic [9:0]      bar_n;
    logic [FW-1:0]   fcnt;
    logic [FW-1:0]   fcnt_n;
    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_n;
    logic            trig_pend;
    logic            trig_n;
    logic            done_pend;
    logic            done_n;
    logic            start_n;
    logic [11:0]     pix_n;
    logic [1:0]      mode_n;
    logic            ft;
    logic            trig_req;
    logic            done_req;
    logic            in_range;
    logic            masked;

    always_comb begin
        state_n = state;
        bar_n   = bar;
        fcnt_n  = fcnt;
        phase_n = phase;
        start_n = 1'b0;
        pix_n   = pixel_in;
        mode_n  = 2'd1;

        ft = (hcount == 11'd0) && (vcount == 10'd0);

        // A request arriving on the frame tick itself counts for that tick.
        trig_req = trig_pend | ((state == S_IDLE) & battle_trigger);
        done_req = done_pend | ((state == S_BATTLE) & battle_done);
        trig_n   = trig_req;
        done_n   = done_req;

        if (ft) begin
            unique case (state)
                S_IDLE: begin
                    if (trig_req) begin
                        state_n = S_FLASH;
                        fcnt_n  = '0;
                        phase_n = '0;
                        trig_n  = 1'b0;
                    end
                end
                S_FLASH: begin
                    if (fcnt == FCNT_LAST) begin
                        fcnt_n = '0;
                        if (phase == PHASE_LAST) begin
                            state_n = S_WIPE;
                            bar_n   = '0;
                            phase_n = '0;
                        end else begin
                            phase_n = phase + PW'(1);
                        end
                    end else begin
                        fcnt_n = fcnt + FW'(1);
                    end
                end
                S_WIPE: begin
                    if (bar + STEP == HALF) begin
                        state_n = S_BATTLE;
                        bar_n   = HALF;
                        start_n = 1'b1;
                    end else begin
                        bar_n = bar + STEP;
                    end
                end
                S_BATTLE: begin
                    if (done_req) begin
                        state_n = S_OPEN;
                        done_n  = 1'b0;
                    end
                end
                S_OPEN: begin
                    if (bar == STEP) begin
                        state_n = S_IDLE;
                        bar_n   = '0;
                    end else begin
                        bar_n = bar - STEP;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        in_range = (hcount < HMAX) && (vcount < VMAX);
        masked   = (vcount < bar) || (vcount >= VMAX - bar);

        case (state)
            S_FLASH: begin
                if (!phase[0]) begin
                    pix_n = pixel_in ^ 12'hFFF;
                end
            end
            S_WIPE, S_OPEN: begin
                if (masked) begin
                    pix_n = 12'h000;
                end
            end
            default: ;
        endcase

        if (!in_range) begin
            pix_n = 12'h000;
        end

        case (state_n)
            S_IDLE:   mode_n = 2'd0;
            S_BATTLE: mode_n = 2'd2;
            default:  mode_n = 2'd1;
        endcase
    end

    always_ff @(posedge vclk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            bar          <= '0;
            fcnt         <= '0;
            phase        <= '0;
            trig_pend    <= 1'b0;
            done_pend    <= 1'b0;
            pixel_out    <= 12'h000;
            game_mode    <= 2'd0;
            freeze       <= 1'b0;
            battle_start <= 1'b0;
        end else begin
            state        <= state_n;
            bar          <= bar_n;
            fcnt         <= fcnt_n;
            phase        <= phase_n;
            trig_pend    <= trig_n;
            done_pend    <= done_n;
            pixel_out    <= pix_n;
            game_mode    <= mode_n;
            freeze       <= (state_n != S_IDLE);
            battle_start <= start_n;
        end
    end

endmodule

// File: tb/tb_battle_transition.sv
// tb_battle_transition: randomized self-checking bench for battle_transition.
// Frames are compressed: each frame is one (0,0) tick plus a few sample pixels.
module tb_battle_transition;

    localparam int H  = 1024;
    localparam int V  = 768;
    localparam int FF = 4;
    localparam int FC = 3;
    localparam int WS = 8;
    localparam int FLASH_LEN = FF * 2 * FC;
    localparam int WIPE_LEN  = (V / 2) / WS;
    localparam int NS = 8;

    // model phase names
    localparam int M_IDLE   = 0;
    localparam int M_FLASH  = 1;
    localparam int M_WIPE   = 2;
    localparam int M_BATTLE = 3;
    localparam int M_OPEN   = 4;

    logic        vclk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        battle_trigger;
    logic        battle_done;
    logic [11:0] pixel_in;
    logic [11:0] pixel_out;
    logic [1:0]  game_mode;
    logic        freeze;
    logic        battle_start;

    int m_st;
    int m_idx;
    bit m_trig;
    bit m_done;

    logic [11:0] exp_pix;
    logic [3:0]  exp_ctl;
    int n_cmp;
    int n_bad;

    always #5 vclk = ~vclk;

    battle_transition #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .FLASH_FRAMES(FF),
        .FLASH_COUNT(FC),
        .WIPE_STEP(WS)
    ) dut (
        .vclk(vclk),
        .reset(reset),
        .hcount(hcount),
        .vcount(vcount),
        .battle_trigger(battle_trigger),
        .battle_done(battle_done),
        .pixel_in(pixel_in),
        .pixel_out(pixel_out),
        .game_mode(game_mode),
        .freeze(freeze),
        .battle_start(battle_start)
    );

    function automatic int m_bar();
        if (m_st == M_WIPE)   return m_idx * WS;
        if (m_st == M_BATTLE) return V / 2;
        if (m_st == M_OPEN)   return V / 2 - m_idx * WS;
        return 0;
    endfunction

    function automatic logic [11:0] model_pixel(int h, int v, logic [11:0] pin);
        int b;
        if (h >= H || v >= V) return 12'h000;
        if (m_st == M_FLASH) return (((m_idx / FF) % 2) == 0) ? ~pin : pin;
        if (m_st == M_WIPE || m_st == M_OPEN) begin
            b = m_bar();
            if (v < b || v >= V - b) return 12'h000;
        end
        return pin;
    endfunction

    function automatic logic [1:0] mode_of(int st);
        if (st == M_IDLE)   return 2'd0;
        if (st == M_BATTLE) return 2'd2;
        return 2'd1;
    endfunction

    task automatic model_reset();
        m_st   = M_IDLE;
        m_idx  = 0;
        m_trig = 0;
        m_done = 0;
    endtask

    // Drive one cycle and advance the reference model; expectations land in
    // exp_pix / exp_ctl for the caller to compare.
    task automatic drive(input int h, input int v, input bit trg, input bit dn,
                         input logic [11:0] pin);
        bit ft;
        int prev;
        hcount         = h[10:0];
        vcount         = v[9:0];
        battle_trigger = trg;
        battle_done    = dn;
        pixel_in       = pin;
        exp_pix = model_pixel(h, v, pin);
        ft   = (h == 0 && v == 0);
        prev = m_st;
        @(posedge vclk);
        if (trg && m_st == M_IDLE)  m_trig = 1;
        if (dn && m_st == M_BATTLE) m_done = 1;
        if (ft) begin
            case (m_st)
                M_IDLE: if (m_trig) begin
                    m_st = M_FLASH; m_idx = 0; m_trig = 0;
                end
                M_FLASH: begin
                    m_idx++;
                    if (m_idx == FLASH_LEN) begin m_st = M_WIPE; m_idx = 0; end
                end
                M_WIPE: begin
                    m_idx++;
                    if (m_idx == WIPE_LEN) begin m_st = M_BATTLE; m_idx = 0; end
                end
                M_BATTLE: if (m_done) begin
                    m_st = M_OPEN; m_idx = 0; m_done = 0;
                end
                M_OPEN: begin
                    m_idx++;
                    if (m_idx == WIPE_LEN) begin m_st = M_IDLE; m_idx = 0; end
                end
                default: m_st = M_IDLE;
            endcase
        end
        exp_ctl = {mode_of(m_st), m_st != M_IDLE, prev == M_WIPE && m_st == M_BATTLE};
        #1;
        battle_trigger = 1'b0;
        battle_done    = 1'b0;
    endtask

    // Sample position s of a frame: 0 is the frame tick, 1..4 hug the bar
    // edges, 5 is a fixed on-screen probe, the rest are random.
    task automatic pick(input int s, output int h, output int v);
        int b;
        b = m_bar();
        h = $urandom_range(1, H - 1);
        case (s)
            0: begin h = 0; v = 0; end
            1: v = (b > 0) ? b - 1 : $urandom_range(0, V - 1);
            2: v = b;
            3: v = V - b - 1;
            4: v = V - b;
            5: begin h = 100; v = 400; end
            default: begin
                h = $urandom_range(1, 1100);
                v = $urandom_range(0, 799);
            end
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hcount = 0; vcount = 0;
        battle_trigger = 0; battle_done = 0;
        pixel_in = 12'hABC;
        model_reset();
        @(posedge vclk);
        #1;
        n_cmp++;
        if (pixel_out !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_pix got %h exp 000", pixel_out);
        end
        n_cmp++;
        if ({game_mode, freeze, battle_start} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl got %b exp 0000", {game_mode, freeze, battle_start});
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        int h, v;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < NS; s++) begin
                pick(s, h, v);
                drive(h, v, 0, 1, 12'($urandom));
                n_cmp++;
                if (pixel_out !== exp_pix) begin
                    n_bad++;
                    $display("FAIL idle_pix h=%0d v=%0d got %h exp %h", h, v, pixel_out, exp_pix);
                end
                n_cmp++;
                if ({game_mode, freeze, battle_start} !== exp_ctl) begin
                    n_bad++;
                    $display("FAIL idle_ctl got %b exp %b", {game_mode, freeze, battle_start}, exp_ctl);
                end
            end
        end
        drive(1100, 10, 0, 0, 12'hFFF);
        n_cmp++;
        if (pixel_out !== 12'h000) begin
            n_bad++;
            $display("FAIL idle_hblank got %h exp 000", pixel_out);
        end
        drive(10, 780, 0, 0, 12'h5A5);
        n_cmp++;
        if (pixel_out !== 12'h000) begin
            n_bad++;
            $display("FAIL idle_vblank got %h exp 000", pixel_out);
        end
    endtask

    task automatic test_flash();
        int h, v;
        logic [11:0] pin;
        drive(500, 300, 1, 0, 12'($urandom));
        n_cmp++;
        if ({game_mode, freeze} !== 3'b000) begin
            n_bad++;
            $display("FAIL flash_pending got %b exp 000", {game_mode, freeze});
        end
        for (int f = 0; f <= FLASH_LEN; f++) begin
            for (int s = 0; s < NS; s++) begin
                pick(s, h, v);
                pin = (s == 5) ? 12'h123 : 12'($urandom);
                drive(h, v, (f == 10 && s == 3), 0, pin);
                n_cmp++;
                if (pixel_out !== exp_pix) begin
                    n_bad++;
                    $display("FAIL flash_pix f=%0d h=%0d v=%0d got %h exp %h", f, h, v, pixel_out, exp_pix);
                end
                n_cmp++;
                if ({game_mode, freeze, battle_start} !== exp_ctl) begin
                    n_bad++;
                    $display("FAIL flash_ctl f=%0d got %b exp %b", f, {game_mode, freeze, battle_start}, exp_ctl);
                end
                if (s == 5 && f < 8) begin
                    n_cmp++;
                    if (pixel_out !== ((f < 4) ? 12'hEDC : 12'h123)) begin
                        n_bad++;
                        $display("FAIL flash_probe f=%0d got %h", f, pixel_out);
                    end
                end
            end
        end
    endtask

    task automatic test_wipe();
        int h, v;
        for (int f = 0; f < WIPE_LEN; f++) begin
            for (int s = 0; s < NS; s++) begin
                pick(s, h, v);
                drive(h, v, 0, (f == 10 && s == 3), 12'($urandom));
                n_cmp++;
                if (pixel_out !== exp_pix) begin
                    n_bad++;
                    $display("FAIL wipe_pix f=%0d h=%0d v=%0d got %h exp %h", f, h, v, pixel_out, exp_pix);
                end
                n_cmp++;
                if ({game_mode, freeze, battle_start} !== exp_ctl) begin
                    n_bad++;
                    $display("FAIL wipe_ctl f=%0d s=%0d got %b exp %b", f, s, {game_mode, freeze, battle_start}, exp_ctl);
                end
            end
        end
    endtask

    task automatic test_battle();
        int h, v;
        for (int f = 0; f < 4; f++) begin
            for (int s = 0; s < NS; s++) begin
                pick(s, h, v);
                drive(h, v, (s == 2), (f == 3 && s == 4), 12'($urandom));
                n_cmp++;
                if (pixel_out !== exp_pix) begin
                    n_bad++;
                    $display("FAIL battle_pix f=%0d h=%0d v=%0d got %h exp %h", f, h, v, pixel_out, exp_pix);
                end
                n_cmp++;
                if ({game_mode, freeze, battle_start} !== exp_ctl) begin
                    n_bad++;
                    $display("FAIL battle_ctl f=%0d s=%0d got %b exp %b", f, s, {game_mode, freeze, battle_start}, exp_ctl);
                end
            end
        end
    endtask

    task automatic test_open();
        int h, v;
        for (int f = 0; f <= WIPE_LEN; f++) begin
            for (int s = 0; s < NS; s++) begin
                pick(s, h, v);
                drive(h, v, 0, 0, 12'($urandom));
                n_cmp++;
                if (pixel_out !== exp_pix) begin
                    n_bad++;
                    $display("FAIL open_pix f=%0d h=%0d v=%0d got %h exp %h", f, h, v, pixel_out, exp_pix);
                end
                n_cmp++;
                if ({game_mode, freeze, battle_start} !== exp_ctl) begin
                    n_bad++;
                    $display("FAIL open_ctl f=%0d got %b exp %b", f, {game_mode, freeze, battle_start}, exp_ctl);
                end
            end
        end
        n_cmp++;
        if ({game_mode, freeze} !== 3'b000) begin
            n_bad++;
            $display("FAIL open_exit got %b exp 000", {game_mode, freeze});
        end
    endtask

    // Trigger lands on the frame tick itself, run into WIPE until bar=200,
    // then pull reset mid-frame.
    task automatic test_reset_mid_wipe();
        int h, v;
        drive(0, 0, 1, 0, 12'($urandom));
        n_cmp++;
        if ({game_mode, freeze, battle_start} !== exp_ctl) begin
            n_bad++;
            $display("FAIL same_tick_ctl got %b exp %b", {game_mode, freeze, battle_start}, exp_ctl);
        end
        for (int f = 0; f < FLASH_LEN + 25; f++) begin
            for (int s = 0; s < 3; s++) begin
                pick(s, h, v);
                drive(h, v, 0, 0, 12'($urandom));
                n_cmp++;
                if (pixel_out !== exp_pix) begin
                    n_bad++;
                    $display("FAIL b2b_pix f=%0d h=%0d v=%0d got %h exp %h", f, h, v, pixel_out, exp_pix);
                end
            end
        end
        hcount = 11'd100;
        vcount = 10'd400;
        pixel_in = 12'h777;
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge vclk);
        #1;
        n_cmp++;
        if ({pixel_out, game_mode, freeze, battle_start} !== 16'h0000) begin
            n_bad++;
            $display("FAIL midwipe_reset got %h/%b exp 000/0000", pixel_out, {game_mode, freeze, battle_start});
        end
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < NS; s++) begin
                pick(s, h, v);
                drive(h, v, 0, 0, 12'($urandom));
                n_cmp++;
                if (pixel_out !== exp_pix) begin
                    n_bad++;
                    $display("FAIL post_reset_pix h=%0d v=%0d got %h exp %h", h, v, pixel_out, exp_pix);
                end
                n_cmp++;
                if ({game_mode, freeze, battle_start} !== exp_ctl) begin
                    n_bad++;
                    $display("FAIL post_reset_ctl got %b exp %b", {game_mode, freeze, battle_start}, exp_ctl);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_idle();
        test_flash();
        test_wipe();
        test_battle();
        test_open();
        test_reset_mid_wipe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
